// File: rtl/uart_tx_fifo.sv
// UART transmitter (8 data bits, LSB first) fed by a small byte FIFO.
// Define UART_TX_PARITY_EN to insert a parity bit after bit 7; PARITY_ODD selects odd or even parity.
module uart_tx_fifo #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx_line,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int unsigned AW           = $clog2(FIFO_DEPTH);
  localparam int unsigned CW           = AW + 1;
  localparam logic [15:0] BIT_LAST     = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] STOP_LAST    = 16'(STOP_BITS * CLKS_PER_BIT - 1);

  // Reject parameter sets the datapath cannot represent.
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD > 1 || CLKS_PER_BIT < 2) begin : g_param_check
    $error("uart_tx_fifo: unsupported parameter set");
  end

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic [CW-1:0] count_n;
  logic [7:0]    head;

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic [7:0]  shift, shift_n;
  logic        line_n;
  logic        busy_n;
  logic        done_n;
`ifdef UART_TX_PARITY_EN
  logic        parity_bit, parity_n;
`endif

  assign push    = tx_valid && tx_ready;
  assign head    = mem[rd_ptr];
  assign count_n = fifo_count + CW'(push) - CW'(pop);

  // FIFO pointers and occupancy; ready is registered from the next count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      tx_ready   <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= count_n;
      tx_ready   <= (count_n < CW'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  // Transmitter state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx_line <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
      tx_line <= line_n;
      tx_busy <= busy_n;
      tx_done <= done_n;
`ifdef UART_TX_PARITY_EN
      parity_bit <= parity_n;
`endif
    end
  end

  // Next-state and registered-output values.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    line_n    = tx_line;
    busy_n    = tx_busy;
    done_n    = 1'b0;
    pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_n  = parity_bit;
`endif
    case (state)
      IDLE: begin
        line_n = 1'b1;
        busy_n = 1'b0;
        if (fifo_count != '0) begin
          pop     = 1'b1;
          shift_n = head;
`ifdef UART_TX_PARITY_EN
          parity_n = (^head) ^ 1'(PARITY_ODD);
`endif
          cnt_n   = '0;
          state_n = START;
          line_n  = 1'b0;
          busy_n  = 1'b1;
        end
      end
      START: begin
        if (cnt == BIT_LAST) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = DATA;
          line_n    = shift[0];
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n = '0;
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
            line_n  = parity_bit;
`else
            state_n = STOP;
            line_n  = 1'b1;
`endif
          end else begin
            shift_n   = {1'b0, shift[7:1]};
            bit_idx_n = bit_idx + 3'd1;
            line_n    = shift[1];
          end
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (cnt == BIT_LAST) begin
          cnt_n   = '0;
          state_n = STOP;
          line_n  = 1'b1;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
`endif
      STOP: begin
        if (cnt == STOP_LAST) begin
          cnt_n  = '0;
          done_n = 1'b1;
          // Chain straight into the next frame when a byte is waiting.
          if (fifo_count != '0) begin
            pop     = 1'b1;
            shift_n = head;
`ifdef UART_TX_PARITY_EN
            parity_n = (^head) ^ 1'(PARITY_ODD);
`endif
            state_n = START;
            line_n  = 1'b0;
          end else begin
            state_n = IDLE;
            busy_n  = 1'b0;
          end
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised scoreboard bench for uart_tx_fifo: transaction-level model plus serial-line receiver.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  localparam int unsigned CLK_FREQ = 1000000;
  localparam int unsigned BAUD     = 100000;
  localparam int unsigned CPB      = 10;
  localparam int unsigned DEPTH    = 4;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned P = 1;
`else
  localparam int unsigned P = 0;
`endif
  localparam int unsigned FRAME1 = (10 + P) * CPB;
  localparam int unsigned FRAME2 = (11 + P) * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_line, tx_busy, tx_done;
  logic [2:0] fifo_count;

  logic [7:0] d2_data = 8'h00;
  logic       d2_valid = 1'b0;
  logic       d2_ready, d2_line, d2_busy, d2_done;
  logic [2:0] d2_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q [$];
  logic [7:0] m_q [$];
  logic [7:0] stim [$];
  int         m_left = 0;
  logic       m_done = 1'b0;
  logic       m_popped = 1'b0;
  int         peak = 0;

  uart_tx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .FIFO_DEPTH(DEPTH),
                 .STOP_BITS(1), .PARITY_ODD(0)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_line(tx_line), .tx_busy(tx_busy), .tx_done(tx_done),
    .fifo_count(fifo_count));

  uart_tx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .FIFO_DEPTH(DEPTH),
                 .STOP_BITS(2), .PARITY_ODD(1)) dut2 (
    .clk(clk), .reset(reset), .tx_data(d2_data), .tx_valid(d2_valid),
    .tx_ready(d2_ready), .tx_line(d2_line), .tx_busy(d2_busy), .tx_done(d2_done),
    .fifo_count(d2_count));

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: a frame occupies the transmitter for FRAME1 edges; the
  // head byte is taken when the transmitter is idle or on the frame's last edge.
  always @(negedge clk) begin
    if (reset) begin
      chk("rst_line", int'(tx_line), 1);
      chk("rst_busy", int'(tx_busy), 0);
      chk("rst_done", int'(tx_done), 0);
      chk("rst_ready", int'(tx_ready), 1);
      chk("rst_count", int'(fifo_count), 0);
      m_q.delete();
      m_left   = 0;
      m_done   = 1'b0;
      m_popped = 1'b0;
    end else begin
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
      chk("ready", int'(tx_ready), int'(m_q.size() < DEPTH));
      chk("count", int'(fifo_count), m_q.size());
      chk("busy", int'(tx_busy), int'(m_left > 0));
      chk("done", int'(tx_done), int'(m_done));
      if (m_popped) chk("line_start", int'(tx_line), 0);
      else if (m_left == 0) chk("line_idle", int'(tx_line), 1);
      begin
        logic accept;
        accept   = tx_valid && (m_q.size() < DEPTH);
        m_done   = (m_left == 1);
        m_popped = 1'b0;
        if (m_left <= 1 && m_q.size() > 0) begin
          exp_q.push_back(m_q.pop_front());
          m_left   = FRAME1;
          m_popped = 1'b1;
        end else if (m_left > 0) begin
          m_left--;
        end
        if (accept) m_q.push_back(tx_data);
      end
    end
  end

  // Serial receiver: captures each frame sample-by-sample and scores it.
  logic mon_in = 1'b0;
  int   mon_k = 0;
  logic mon_s [FRAME1];

  task automatic check_frame();
    logic [7:0] b;
    int bad;
    bad = 0;
    for (int i = 0; i < FRAME1; i++)
      if (mon_s[i] != mon_s[(i / CPB) * CPB]) bad++;
    for (int d = 0; d < 8; d++) b[d] = mon_s[(1 + d) * CPB];
    chk("bit_hold", bad, 0);
    chk("stop_bit", int'(mon_s[(9 + P) * CPB]), 1);
`ifdef UART_TX_PARITY_EN
    chk("parity", int'(mon_s[9 * CPB]), int'(^b));
`endif
    chk("frame_expected", int'(exp_q.size() != 0), 1);
    if (exp_q.size() != 0) chk("rx_byte", int'(b), int'(exp_q.pop_front()));
  endtask

  always @(negedge clk) begin
    if (reset) begin
      mon_in = 1'b0;
      exp_q.delete();
    end else if (!mon_in) begin
      if (!tx_line) begin
        mon_in    = 1'b1;
        mon_k     = 0;
        mon_s[0]  = tx_line;
      end
    end else begin
      mon_k++;
      mon_s[mon_k] = tx_line;
      if (mon_k == FRAME1 - 1) begin
        check_frame();
        mon_in = 1'b0;
      end
    end
  end

  task automatic burst();
    while (stim.size() > 0) begin
      tx_data  = stim.pop_front();
      tx_valid = 1'b1;
      @(posedge clk); #1;
    end
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!(m_left == 0 && m_q.size() == 0) && n < 4000) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_drain"}, int'(n < 4000), 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Two-stop-bit instance: one frame captured directly and checked in place.
  task automatic sb2_test();
    logic s [FRAME2 + 1];
    logic dseen;
    logic [7:0] b;
    int bad;
    d2_data  = 8'h3C;
    d2_valid = 1'b1;
    @(posedge clk); #1;
    d2_valid = 1'b0;
    @(negedge clk);
    chk("sb2_pre_start", int'(d2_line), 1);
    dseen = 1'b0;
    for (int i = 0; i <= FRAME2; i++) begin
      @(negedge clk);
      s[i] = d2_line;
      if (i < FRAME2 && d2_done) dseen = 1'b1;
      if (i == FRAME2) begin
        chk("sb2_done_at_end", int'(d2_done), 1);
        chk("sb2_busy_after", int'(d2_busy), 0);
      end
    end
    chk("sb2_early_done", int'(dseen), 0);
    bad = 0;
    for (int i = 0; i < FRAME2; i++)
      if (s[i] != s[(i / CPB) * CPB]) bad++;
    chk("sb2_bit_hold", bad, 0);
    chk("sb2_start", int'(s[0]), 0);
    chk("sb2_stop1", int'(s[(9 + P) * CPB]), 1);
    chk("sb2_stop2", int'(s[(10 + P) * CPB]), 1);
    for (int d = 0; d < 8; d++) b[d] = s[(1 + d) * CPB];
    chk("sb2_byte", int'(b), 8'h3C);
`ifdef UART_TX_PARITY_EN
    chk("sb2_parity_odd", int'(s[9 * CPB]), int'(~(^b)));
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    stim = '{8'hA5};
    burst();
    wait_idle("single");

    peak = 0;
    stim = '{8'h00, 8'hFF, 8'h55};
    burst();
    @(negedge clk); #1;
    chk("b2b_peak", peak, 2);
    wait_idle("b2b");

    for (int i = 0; i < 7; i++) stim.push_back(8'(8'h10 + i));
    burst();
    chk("full_ready_low", int'(tx_ready), 0);
    wait_idle("full");

    stim = '{8'h07, 8'h03};
    burst();
    wait_idle("parity_pair");

    for (int i = 0; i < 150; i++) begin
      tx_valid = ($urandom_range(0, 7) == 0);
      tx_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    tx_valid = 1'b0;
    wait_idle("random");

    stim = '{8'hC3, 8'h3C, 8'h99};
    burst();
    repeat (43) @(posedge clk);
    chk("rst_pre_busy", int'(tx_busy), 1);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_line", int'(tx_line), 1);
    chk("rst_mid_busy", int'(tx_busy), 0);
    chk("rst_mid_count", int'(fifo_count), 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    chk("post_rst_line", int'(tx_line), 1);

    sb2_test();

    chk("frames_pending", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
